csr_trap_ctrl: RTL and testbench

Trap/interrupt sequencer and access arbiter for the machine-mode CSR file (mip, mie, mstatus, mcause, mtvec, mepc). It owns the CSR file's single read/write port and shares it between pipeline CSR instructions and its own multi-cycle trap-entry and mret sequences. It produces a one-cycle PC redirect to the fetch stage.

---
 rtl/csr_trap_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/interrupt sequencer and CSR port arbiter.
// Shares the single CSR port between pipeline accesses and trap/mret sequences.
module csr_trap_ctrl #(
   parameter int XLEN          = 32,
   parameter int IRQ_EXT_CAUSE = 11,
   parameter int IRQ_TMR_CAUSE = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_csr_rd,
   input  logic            pipe_csr_wr,
   input  logic [11:0]     pipe_csr_addr,
   input  logic [XLEN-1:0] pipe_csr_wdata,
   output logic [XLEN-1:0] pipe_csr_rdata,
   output logic            pipe_stall,
   input  logic            exc_valid,
   input  logic [4:0]      exc_cause,
   input  logic            mret_req,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            irq_ext,
   input  logic            irq_timer,
   output logic            trap_ack,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            csr_reg_rdpin,
   output logic            csr_reg_wrpin,
   output logic [31:0]     csr_addr32,
   output logic [XLEN-1:0] csr_wdata,
   input  logic [XLEN-1:0] csr_rdata
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHK_MSTATUS,
      S_CHK_MIE,
      S_WR_MEPC,
      S_WR_MCAUSE,
      S_WR_MSTATUS,
      S_RD_MTVEC,
      S_MR_MSTATUS,
      S_MR_MEPC
   } state_e;

   state_e            state_q, state_d;
   logic              irq_hold_q, irq_hold_d;
   logic              is_irq_q, is_irq_d;
   logic [4:0]        cause_q, cause_d;
   logic [XLEN-1:2]   pc_q, pc_d;
   logic              ext_prev_q, ext_prev_d;
   logic              tmr_prev_q, tmr_prev_d;

   logic              irq_pend;
   logic              trap_req;
   logic              pipe_pass;
   logic              pipe_clr;
   logic              irq_chg;
   logic              ext_en;
   logic              tmr_en;
   logic [XLEN-1:0]   rd_base;
   logic              unused_pc_lsb;

   assign unused_pc_lsb = ^trap_pc[1:0];

   assign irq_pend  = (irq_ext | irq_timer) & ~irq_hold_q;
   assign trap_req  = exc_valid | mret_req | irq_pend;
   assign pipe_pass = (state_q == S_IDLE) & ~trap_req;
   assign pipe_clr  = pipe_pass & pipe_csr_wr &
                      ((pipe_csr_addr == A_MSTATUS) |
                       (pipe_csr_addr == A_MIE));
   assign irq_chg   = (irq_ext != ext_prev_q) | (irq_timer != tmr_prev_q);
   assign ext_en    = irq_ext & csr_rdata[11];
   assign tmr_en    = irq_timer & csr_rdata[7];
   assign rd_base   = {csr_rdata[XLEN-1:2], 2'b00};
   assign ext_prev_d = irq_ext;
   assign tmr_prev_d = irq_timer;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         irq_hold_q <= 1'b0;
         is_irq_q   <= 1'b0;
         cause_q    <= '0;
         pc_q       <= '0;
         ext_prev_q <= 1'b0;
         tmr_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         irq_hold_q <= irq_hold_d;
         is_irq_q   <= is_irq_d;
         cause_q    <= cause_d;
         pc_q       <= pc_d;
         ext_prev_q <= ext_prev_d;
         tmr_prev_q <= tmr_prev_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      irq_hold_d = irq_hold_q;
      is_irq_d   = is_irq_q;
      cause_d    = cause_q;
      pc_d       = pc_q;
      if (irq_chg || pipe_clr) irq_hold_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (exc_valid) begin
               state_d  = S_WR_MEPC;
               cause_d  = exc_cause;
               is_irq_d = 1'b0;
               pc_d     = trap_pc[XLEN-1:2];
            end else if (mret_req) begin
               state_d  = S_MR_MSTATUS;
               pc_d     = trap_pc[XLEN-1:2];
            end else if (irq_pend) begin
               state_d  = S_CHK_MSTATUS;
               is_irq_d = 1'b1;
               pc_d     = trap_pc[XLEN-1:2];
            end
         end
         S_CHK_MSTATUS: begin
            if (!csr_rdata[3]) begin
               irq_hold_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               state_d    = S_CHK_MIE;
            end
         end
         S_CHK_MIE: begin
            if (ext_en) begin
               cause_d = 5'(IRQ_EXT_CAUSE);
               state_d = S_WR_MEPC;
            end else if (tmr_en) begin
               cause_d = 5'(IRQ_TMR_CAUSE);
               state_d = S_WR_MEPC;
            end else begin
               irq_hold_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         S_WR_MEPC:    state_d = S_WR_MCAUSE;
         S_WR_MCAUSE:  state_d = S_WR_MSTATUS;
         S_WR_MSTATUS: state_d = S_RD_MTVEC;
         S_RD_MTVEC:   state_d = S_IDLE;
         S_MR_MSTATUS: state_d = S_MR_MEPC;
         S_MR_MEPC:    state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pipe_csr_rdata = '0;
      pipe_stall     = 1'b1;
      trap_ack       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      csr_reg_rdpin  = 1'b0;
      csr_reg_wrpin  = 1'b0;
      csr_addr32     = '0;
      csr_wdata      = '0;
      unique case (state_q)
         S_IDLE: begin
            if (!trap_req) begin
               pipe_stall     = 1'b0;
               csr_reg_rdpin  = pipe_csr_rd;
               csr_reg_wrpin  = pipe_csr_wr;
               csr_addr32     = {20'd0, pipe_csr_addr};
               csr_wdata      = pipe_csr_wdata;
               pipe_csr_rdata = pipe_csr_rd ? csr_rdata : '0;
            end
         end
         S_CHK_MSTATUS: begin
            csr_reg_rdpin = 1'b1;
            csr_addr32    = {20'd0, A_MSTATUS};
         end
         S_CHK_MIE: begin
            csr_reg_rdpin = 1'b1;
            csr_addr32    = {20'd0, A_MIE};
         end
         S_WR_MEPC: begin
            csr_reg_wrpin = 1'b1;
            csr_addr32    = {20'd0, A_MEPC};
            csr_wdata     = {pc_q, 2'b00};
         end
         S_WR_MCAUSE: begin
            csr_reg_wrpin = 1'b1;
            csr_addr32    = {20'd0, A_MCAUSE};
            csr_wdata     = {is_irq_q, {(XLEN-6){1'b0}}, cause_q};
         end
         S_WR_MSTATUS: begin
            csr_reg_rdpin     = 1'b1;
            csr_reg_wrpin     = 1'b1;
            csr_addr32        = {20'd0, A_MSTATUS};
            csr_wdata         = csr_rdata;
            csr_wdata[7]      = csr_rdata[3];
            csr_wdata[3]      = 1'b0;
            csr_wdata[12:11]  = 2'b11;
         end
         S_RD_MTVEC: begin
            csr_reg_rdpin  = 1'b1;
            csr_addr32     = {20'd0, A_MTVEC};
            redirect_valid = 1'b1;
            trap_ack       = 1'b1;
            // vectored mode only offsets interrupts
            if (csr_rdata[1:0] == 2'b01 && is_irq_q)
               redirect_pc = rd_base + XLEN'({cause_q, 2'b00});
            else
               redirect_pc = rd_base;
         end
         S_MR_MSTATUS: begin
            csr_reg_rdpin = 1'b1;
            csr_reg_wrpin = 1'b1;
            csr_addr32    = {20'd0, A_MSTATUS};
            csr_wdata     = csr_rdata;
            csr_wdata[3]  = csr_rdata[7];
            csr_wdata[7]  = 1'b1;
         end
         S_MR_MEPC: begin
            csr_reg_rdpin  = 1'b1;
            csr_addr32     = {20'd0, A_MEPC};
            redirect_valid = 1'b1;
            trap_ack       = 1'b1;
            redirect_pc    = rd_base;
         end
         default: ;
      endcase
      if (!rst) begin
         pipe_csr_rdata = '0;
         pipe_stall     = 1'b0;
         trap_ack       = 1'b0;
         redirect_valid = 1'b0;
         redirect_pc    = '0;
         csr_reg_rdpin  = 1'b0;
         csr_reg_wrpin  = 1'b0;
         csr_addr32     = '0;
         csr_wdata      = '0;
      end
   end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl with a behavioural CSR file.
// Redirects and pipeline reads are checked by a monitor against queued expectations.
module tb_csr_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pipe_csr_rd = 1'b0;
   logic        pipe_csr_wr = 1'b0;
   logic [11:0] pipe_csr_addr = '0;
   logic [31:0] pipe_csr_wdata = '0;
   logic [31:0] pipe_csr_rdata;
   logic        pipe_stall;
   logic        exc_valid = 1'b0;
   logic [4:0]  exc_cause = '0;
   logic        mret_req = 1'b0;
   logic [31:0] trap_pc = '0;
   logic        irq_ext = 1'b0;
   logic        irq_timer = 1'b0;
   logic        trap_ack;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        csr_reg_rdpin;
   logic        csr_reg_wrpin;
   logic [31:0] csr_addr32;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;

   csr_trap_ctrl #(.XLEN(32), .IRQ_EXT_CAUSE(11), .IRQ_TMR_CAUSE(7)) dut (
      .clk(clk), .rst(rst),
      .pipe_csr_rd(pipe_csr_rd), .pipe_csr_wr(pipe_csr_wr),
      .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
      .pipe_csr_rdata(pipe_csr_rdata), .pipe_stall(pipe_stall),
      .exc_valid(exc_valid), .exc_cause(exc_cause),
      .mret_req(mret_req), .trap_pc(trap_pc),
      .irq_ext(irq_ext), .irq_timer(irq_timer),
      .trap_ack(trap_ack), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .csr_reg_rdpin(csr_reg_rdpin), .csr_reg_wrpin(csr_reg_wrpin),
      .csr_addr32(csr_addr32), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata)
   );

   always #5 clk = ~clk;

   // behavioural CSR file: combinational read, posedge write
   bit [31:0] csr_mem [0:4095];
   always @(posedge clk)
      if (csr_reg_wrpin) csr_mem[csr_addr32[11:0]] <= csr_wdata;
   assign csr_rdata = csr_mem[csr_addr32[11:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pc;
      int          at;
   } exp_t;

   exp_t        redq[$];
   logic [31:0] rdq[$];
   int tests = 0;
   int fails = 0;
   int redir_cnt = 0;

   function automatic void check(string name, logic [31:0] act,
                                 logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   always begin
      @(negedge clk);
      #2;
      if (rst && pipe_csr_rd && !pipe_stall) begin
         if (rdq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_read: got %h, expected none",
                     pipe_csr_rdata);
         end else begin
            check("pipe_rdata", pipe_csr_rdata, rdq.pop_front());
         end
      end
      if (redirect_valid) begin
         redir_cnt++;
         if (redq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_redirect: got %h, expected none",
                     redirect_pc);
         end else begin
            exp_t e;
            e = redq.pop_front();
            check("redirect_pc", redirect_pc, e.pc);
            check("trap_ack", 32'(trap_ack), 32'd1);
            if (e.at >= 0) check("redirect_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   task automatic pipe_acc(input logic rd, input logic wr,
                           input logic [11:0] a, input logic [31:0] d,
                           input logic [31:0] exp, output int stalls);
      stalls = 0;
      @(negedge clk);
      pipe_csr_rd = rd;
      pipe_csr_wr = wr;
      pipe_csr_addr = a;
      pipe_csr_wdata = d;
      if (rd) rdq.push_back(exp);
      for (int i = 0; i < 64; i++) begin
         #2;
         if (!pipe_stall) break;
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 64) begin
         tests++; fails++;
         $display("FAIL pipe_timeout: got %0d stalls, expected < 64", stalls);
      end
      @(negedge clk);
      pipe_csr_rd = 1'b0;
      pipe_csr_wr = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      int s;
      pipe_acc(1'b0, 1'b1, a, d, 32'd0, s);
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp);
      int s;
      pipe_acc(1'b1, 1'b0, a, 32'd0, exp, s);
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         #3;
         if (trap_ack) return;
      end
      tests++; fails++;
      $display("FAIL ack_timeout: got no ack, expected ack within 32 cycles");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int st;
      int rc0;
      int stalls;

      // reset: requests and pipe access present but everything held at 0
      repeat (2) @(negedge clk);
      pipe_csr_rd = 1'b1; pipe_csr_wr = 1'b1;
      pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'h55;
      exc_valid = 1'b1;
      @(negedge clk);
      #2;
      check("rst_rdpin", 32'(csr_reg_rdpin), 32'd0);
      check("rst_wrpin", 32'(csr_reg_wrpin), 32'd0);
      check("rst_addr", csr_addr32, 32'd0);
      check("rst_wdata", csr_wdata, 32'd0);
      check("rst_stall", 32'(pipe_stall), 32'd0);
      check("rst_redirect", 32'(redirect_valid), 32'd0);
      check("rst_ack", 32'(trap_ack), 32'd0);
      check("rst_rdata", pipe_csr_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      pipe_csr_rd = 1'b0; pipe_csr_wr = 1'b0; exc_valid = 1'b0;

      // passthrough
      rd(12'h305, 32'h0);
      rc0 = redir_cnt;
      pipe_acc(1'b0, 1'b1, 12'h305, 32'h1000, 32'd0, st);
      check("pt_wr_stall", 32'(st), 32'd0);
      pipe_acc(1'b1, 1'b0, 12'h305, 32'd0, 32'h1000, st);
      check("pt_rd_stall", 32'(st), 32'd0);
      check("pt_no_redirect", 32'(redir_cnt), 32'(rc0));

      // synchronous exception
      wr(12'h300, 32'h8);
      @(negedge clk);
      exc_valid = 1'b1; exc_cause = 5'd2; trap_pc = 32'h204;
      redq.push_back('{32'h1000, cyc + 4});
      wait_ack();
      @(negedge clk);
      exc_valid = 1'b0;
      rd(12'h341, 32'h204);
      rd(12'h342, 32'h2);
      rd(12'h300, 32'h1880);

      // mret
      wr(12'h341, 32'h206);
      @(negedge clk);
      mret_req = 1'b1;
      redq.push_back('{32'h204, cyc + 2});
      wait_ack();
      @(negedge clk);
      mret_req = 1'b0;
      rd(12'h300, 32'h1888);

      // exception and mret together: exception first, then mret
      wr(12'h300, 32'h8);
      @(negedge clk);
      exc_valid = 1'b1; mret_req = 1'b1;
      exc_cause = 5'd5; trap_pc = 32'h300;
      redq.push_back('{32'h1000, cyc + 4});
      wait_ack();
      @(negedge clk);
      exc_valid = 1'b0;
      redq.push_back('{32'h300, cyc + 2});
      wait_ack();
      @(negedge clk);
      mret_req = 1'b0;
      rd(12'h342, 32'h5);
      rd(12'h300, 32'h1888);

      // vectored timer interrupt
      wr(12'h305, 32'h1001);
      wr(12'h300, 32'h8);
      wr(12'h304, 32'h80);
      @(negedge clk);
      trap_pc = 32'h400; irq_timer = 1'b1;
      redq.push_back('{32'h101C, cyc + 6});
      wait_ack();
      @(negedge clk);
      irq_timer = 1'b0;
      rd(12'h342, 32'h8000_0007);
      rd(12'h341, 32'h400);
      rd(12'h300, 32'h1880);

      // disabled interrupt: one check cycle then held off
      wr(12'h300, 32'h0);
      wr(12'h304, 32'h0);
      wr(12'h305, 32'h2000);
      rc0 = redir_cnt;
      @(negedge clk);
      trap_pc = 32'h500; irq_ext = 1'b1;
      stalls = 0;
      for (int i = 0; i < 10; i++) begin
         #2;
         if (pipe_stall) stalls++;
         @(negedge clk);
      end
      check("dis_stall_cycles", 32'(stalls), 32'd2);
      check("dis_no_redirect", 32'(redir_cnt), 32'(rc0));
      redq.push_back('{32'h2000, -1});
      wr(12'h300, 32'h8);
      wr(12'h304, 32'h800);
      wait_ack();
      @(negedge clk);
      irq_ext = 1'b0;
      rd(12'h342, 32'h8000_000B);
      rd(12'h341, 32'h500);

      // reset in WR_MCAUSE
      wr(12'h342, 32'hDEAD);
      wr(12'h305, 32'h1000);
      @(negedge clk);
      exc_valid = 1'b1; exc_cause = 5'd3; trap_pc = 32'h600;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; exc_valid = 1'b0;
      #2;
      check("mid_rst_wrpin", 32'(csr_reg_wrpin), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #2;
      check("mid_rst_stall", 32'(pipe_stall), 32'd0);
      check("mid_rst_redirect", 32'(redirect_valid), 32'd0);
      check("mid_rst_rdpin", 32'(csr_reg_rdpin), 32'd0);
      rd(12'h341, 32'h600);
      rd(12'h342, 32'hDEAD);
      rd(12'h300, 32'h1880);
      repeat (10) @(negedge clk);

      check("redq_empty", 32'(redq.size()), 32'd0);
      check("rdq_empty", 32'(rdq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
